tdp_ram_arbiter: RTL and testbench

- Shares one true_dual_port_ram (two read/write ports, shared clk) among NUM_REQ requesters.
- Up to two requests are granted per cycle: one on RAM port A and one on RAM port B.
- Grants are round-robin, with address-collision protection between the ports.
- Read data returns to the requester one cycle after grant. The block sits directly between the requester fabric and the RAM instance.

---
 rtl/tdp_ram_arbiter_if.sv | 25 ++
 rtl/tdp_ram_arbiter.sv | 142 ++++++++++++++
 tb/tb_tdp_ram_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdp_ram_arbiter_if.sv
// Requester-side bus of the dual-port RAM arbiter: packed per-requester
// request fields, the combinational grant and the registered read response.
interface tdp_ram_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned ADDR_W  = 6
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*WIDTH-1:0]  req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ*WIDTH-1:0]  rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/tdp_ram_arbiter.sv
// Round-robin arbiter granting up to two requesters per cycle onto the A/B
// ports of a true dual-port RAM, dropping port B on a write address collision.
module tdp_ram_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    tdp_ram_arbiter_if.slave  req_if,
    output logic              ram_we_a,
    output logic              ram_we_b,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic [WIDTH-1:0]  ram_data_a,
    output logic [WIDTH-1:0]  ram_data_b,
    input  logic [WIDTH-1:0]  ram_q_a,
    input  logic [WIDTH-1:0]  ram_q_b,
    output logic [15:0]       conflict_cnt
);

    localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_rdata_q [NUM_REQ];
    logic [WIDTH-1:0]   rsp_rdata_d [NUM_REQ];
    logic [CNT_W-1:0]   conflict_cnt_q, conflict_cnt_d;

    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [WIDTH-1:0]   wdata_arr [NUM_REQ];

    logic               a_found, b_found;
    logic [PTR_W-1:0]   a_idx, b_idx;
    logic               collide_c, grant_a_c, grant_b_c;
    logic [NUM_REQ-1:0] ready_c;

    // Unpack the per-requester buses and pack the response data.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign addr_arr[g]  = req_if.req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_if.req_wdata[g*WIDTH +: WIDTH];
        assign req_if.rsp_rdata[g*WIDTH +: WIDTH] = rsp_rdata_q[g];
    end

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] i);
        return (32'(i) + 32'd1 >= NUM_REQ) ? '0 : PTR_W'(32'(i) + 32'd1);
    endfunction

    // First two valid requesters in round-robin order starting at rr_ptr.
    always_comb begin
        int unsigned idx;
        a_found = 1'b0;
        b_found = 1'b0;
        a_idx   = '0;
        b_idx   = '0;
        idx     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_if.req_valid[PTR_W'(idx)]) begin
                if (!a_found) begin
                    a_found = 1'b1;
                    a_idx   = PTR_W'(idx);
                end else if (!b_found) begin
                    b_found = 1'b1;
                    b_idx   = PTR_W'(idx);
                end
            end
        end
    end

    // Grants, RAM drive and next-state; all idle while reset is asserted.
    always_comb begin
        collide_c = a_found && b_found
                    && (addr_arr[a_idx] == addr_arr[b_idx])
                    && (req_if.req_we[a_idx] || req_if.req_we[b_idx]);
        grant_a_c = rst_n && a_found;
        grant_b_c = rst_n && b_found && !collide_c;

        ready_c    = '0;
        ram_we_a   = 1'b0;
        ram_addr_a = '0;
        ram_data_a = '0;
        ram_we_b   = 1'b0;
        ram_addr_b = '0;
        ram_data_b = '0;

        rr_ptr_d       = rr_ptr_q;
        rsp_valid_d    = '0;
        rsp_rdata_d    = rsp_rdata_q;
        conflict_cnt_d = conflict_cnt_q;

        if (grant_a_c) begin
            ready_c[a_idx] = 1'b1;
            ram_we_a       = req_if.req_we[a_idx];
            ram_addr_a     = addr_arr[a_idx];
            ram_data_a     = wdata_arr[a_idx];
            rr_ptr_d       = next_idx(a_idx);
            if (!req_if.req_we[a_idx]) begin
                rsp_valid_d[a_idx] = 1'b1;
                rsp_rdata_d[a_idx] = ram_q_a;
            end
        end

        if (grant_b_c) begin
            ready_c[b_idx] = 1'b1;
            ram_we_b       = req_if.req_we[b_idx];
            ram_addr_b     = addr_arr[b_idx];
            ram_data_b     = wdata_arr[b_idx];
            rr_ptr_d       = next_idx(b_idx);
            if (!req_if.req_we[b_idx]) begin
                rsp_valid_d[b_idx] = 1'b1;
                rsp_rdata_d[b_idx] = ram_q_b;
            end
        end

        if (rst_n && collide_c && (conflict_cnt_q != CNT_MAX))
            conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q       <= '0;
            rsp_valid_q    <= '0;
            conflict_cnt_q <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) rsp_rdata_q[i] <= '0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            rsp_valid_q    <= rsp_valid_d;
            conflict_cnt_q <= conflict_cnt_d;
            rsp_rdata_q    <= rsp_rdata_d;
        end
    end

    assign req_if.req_ready = ready_c;
    assign req_if.rsp_valid = rsp_valid_q;
    assign conflict_cnt     = conflict_cnt_q;

endmodule

// File: tb/tb_tdp_ram_arbiter.sv
// Self-checking bench: RAM stub, list-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_tdp_ram_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int D  = 64;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst_n;
    logic load_en;
    always #5 clk = ~clk;

    tdp_ram_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .ADDR_W(AW)) bus ();

    logic          ram_we_a, ram_we_b;
    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic [W-1:0]  ram_data_a, ram_data_b, ram_q_a, ram_q_b;
    logic [15:0]   conflict_cnt;

    tdp_ram_arbiter #(.NUM_REQ(N), .WIDTH(W), .DEPTH(D), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .req_if(bus),
        .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
        .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
        .ram_data_a(ram_data_a), .ram_data_b(ram_data_b),
        .ram_q_a(ram_q_a), .ram_q_b(ram_q_b),
        .conflict_cnt(conflict_cnt)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [W-1:0] init_val(input int a);
        return W'(a * 3);
    endfunction

    // RAM stub driven only by the DUT, asynchronous read.
    logic [W-1:0] ram [D];
    assign ram_q_a = ram[ram_addr_a];
    assign ram_q_b = ram[ram_addr_b];
    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < D; i++) ram[i] <= init_val(i);
        end else begin
            if (ram_we_a) ram[ram_addr_a] <= ram_data_a;
            if (ram_we_b) ram[ram_addr_b] <= ram_data_b;
        end
    end

    // Reference model: ordered candidate list from the pointer.
    int            m_ptr, m_cnt;
    logic [N-1:0]  m_rsp_valid;
    logic [N*W-1:0] m_rsp_rdata;
    logic [W-1:0]  m_mem [D];

    int            e_a, e_b;
    logic          e_col;
    logic [N-1:0]  e_ready;
    logic          e_we_a, e_we_b;
    logic [AW-1:0] e_addr_a, e_addr_b;
    logic [W-1:0]  e_data_a, e_data_b;

    function automatic logic [AW-1:0] q_addr(input int i);
        return bus.req_addr[i*AW +: AW];
    endfunction
    function automatic logic [W-1:0] q_wdata(input int i);
        return bus.req_wdata[i*W +: W];
    endfunction

    always_comb begin
        int order [$];
        order = {};
        e_a = -1; e_b = -1; e_col = 1'b0; e_ready = '0;
        e_we_a = 1'b0; e_addr_a = '0; e_data_a = '0;
        e_we_b = 1'b0; e_addr_b = '0; e_data_b = '0;
        if (rst_n === 1'b1) begin
            for (int k = 0; k < N; k++)
                if (bus.req_valid[(m_ptr + k) % N]) order.push_back((m_ptr + k) % N);
            if (order.size() > 0) e_a = order[0];
            if (order.size() > 1) e_b = order[1];
            if (e_a >= 0 && e_b >= 0 && q_addr(e_a) == q_addr(e_b)
                && (bus.req_we[e_a] || bus.req_we[e_b])) begin
                e_col = 1'b1;
                e_b   = -1;
            end
            if (e_a >= 0) begin
                e_ready[e_a] = 1'b1;
                e_we_a = bus.req_we[e_a]; e_addr_a = q_addr(e_a); e_data_a = q_wdata(e_a);
            end
            if (e_b >= 0) begin
                e_ready[e_b] = 1'b1;
                e_we_b = bus.req_we[e_b]; e_addr_b = q_addr(e_b); e_data_b = q_wdata(e_b);
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr <= 0; m_cnt <= 0; m_rsp_valid <= '0; m_rsp_rdata <= '0;
        end else begin
            m_rsp_valid <= '0;
            if (e_a >= 0 && !e_we_a) begin
                m_rsp_valid[e_a] <= 1'b1;
                m_rsp_rdata[e_a*W +: W] <= m_mem[e_addr_a];
            end
            if (e_b >= 0 && !e_we_b) begin
                m_rsp_valid[e_b] <= 1'b1;
                m_rsp_rdata[e_b*W +: W] <= m_mem[e_addr_b];
            end
            if (e_b >= 0)      m_ptr <= (e_b + 1) % N;
            else if (e_a >= 0) m_ptr <= (e_a + 1) % N;
            if (e_col && m_cnt < 65535) m_cnt <= m_cnt + 1;
        end
    end

    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < D; i++) m_mem[i] <= init_val(i);
        end else begin
            if (e_a >= 0 && e_we_a) m_mem[e_addr_a] <= e_data_a;
            if (e_b >= 0 && e_we_b) m_mem[e_addr_b] <= e_data_b;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("ready", 32'(bus.req_ready), 32'(e_ready));
        chk("port_a", {15'd0, ram_we_a, 2'd0, ram_addr_a, ram_data_a},
                      {15'd0, e_we_a, 2'd0, e_addr_a, e_data_a});
        chk("port_b", {15'd0, ram_we_b, 2'd0, ram_addr_b, ram_data_b},
                      {15'd0, e_we_b, 2'd0, e_addr_b, e_data_b});
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_rsp_valid));
        chk("rsp_rdata", bus.rsp_rdata, m_rsp_rdata);
        chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
    end

    function automatic logic [W-1:0] rd(input int i);
        return bus.rsp_rdata[i*W +: W];
    endfunction

    task automatic set_req(input int i, input logic we, input int a, input logic [W-1:0] d);
        bus.req_valid[i] = 1'b1;
        bus.req_we[i] = we;
        bus.req_addr[i*AW +: AW] = AW'(a);
        bus.req_wdata[i*W +: W] = d;
    endtask

    // Close the cycle: granted requests retire if drop is set.
    task automatic end_cycle(input logic drop);
        logic [N-1:0] g;
        g = bus.req_ready;
        @(posedge clk); #1;
        if (drop) bus.req_valid = bus.req_valid & ~g;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; load_en = 1'b1;
        bus.req_valid = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_ram_we", {ram_we_a, ram_we_b}, 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        @(posedge clk); #1;
        load_en = 1'b0; rst_n = 1'b1;

        // Write then read back through requester 0.
        set_req(0, 1'b1, 5, 8'hA5);
        @(negedge clk);
        chk("t1_wr_we_a", 32'(ram_we_a), 32'h1);
        chk("t1_wr_addr_a", 32'(ram_addr_a), 32'd5);
        end_cycle(1'b1);
        set_req(0, 1'b0, 5, 8'h00);
        @(negedge clk);
        chk("t1_rd_ready", 32'(bus.req_ready), 32'b0001);
        end_cycle(1'b1);
        @(negedge clk);
        chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'b0001);
        chk("t1_rsp_rdata", 32'(rd(0)), 32'hA5);
        end_cycle(1'b1);

        // Four continuous readers of addresses 0..3.
        reset_pulse();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, i, 8'h00);
        @(negedge clk);
        chk("t2_c1_ready", 32'(bus.req_ready), 32'b0011);
        end_cycle(1'b0);
        @(negedge clk);
        chk("t2_c2_ready", 32'(bus.req_ready), 32'b1100);
        chk("t2_c2_rsp", {bus.rsp_valid, 4'd0, rd(1), rd(0)}, {4'b0011, 4'd0, 8'h03, 8'h00});
        end_cycle(1'b0);
        @(negedge clk);
        chk("t2_c3_ready", 32'(bus.req_ready), 32'b0011);
        chk("t2_c3_rsp", {bus.rsp_valid, 4'd0, rd(3), rd(2)}, {4'b1100, 4'd0, 8'h09, 8'h06});
        bus.req_valid = '0;
        end_cycle(1'b0);

        // Write collision on address 10.
        reset_pulse();
        set_req(1, 1'b1, 10, 8'h11);
        set_req(2, 1'b1, 10, 8'h22);
        @(negedge clk);
        chk("t3_c1_ready", 32'(bus.req_ready), 32'b0010);
        end_cycle(1'b1);
        @(negedge clk);
        chk("t3_c2_ready", 32'(bus.req_ready), 32'b0100);
        chk("t3_cnt", 32'(conflict_cnt), 32'd1);
        end_cycle(1'b1);
        set_req(0, 1'b0, 10, 8'h00);
        @(negedge clk);
        end_cycle(1'b1);
        @(negedge clk);
        chk("t3_rd", 32'(rd(0)), 32'h22);

        // Two reads of the same address are both granted.
        set_req(0, 1'b0, 20, 8'h00);
        set_req(3, 1'b0, 20, 8'h00);
        @(negedge clk);
        chk("t4_ready", 32'(bus.req_ready), 32'b1001);
        end_cycle(1'b1);
        @(negedge clk);
        chk("t4_rsp", {bus.rsp_valid, 8'd0, rd(3), rd(0)}, {4'b1001, 8'd0, 8'h3C, 8'h3C});
        end_cycle(1'b1);

        // Reset right after a read grant drops the response.
        set_req(1, 1'b0, 5, 8'h00);
        @(negedge clk);
        chk("t5_ready", 32'(bus.req_ready), 32'b0010);
        end_cycle(1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rsp_dropped", 32'(bus.rsp_valid), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_req(1, 1'b0, 5, 8'h00);
        set_req(2, 1'b0, 30, 8'h00);
        set_req(3, 1'b0, 31, 8'h00);
        @(negedge clk);
        chk("t5_cnt_cleared", 32'(conflict_cnt), 32'h0);
        chk("t5_ptr0_ready", 32'(bus.req_ready), 32'b0110);
        end_cycle(1'b1);
        @(negedge clk);
        chk("t5_next_ready", 32'(bus.req_ready), 32'b1000);
        chk("t5_rd", 32'(rd(1)), 32'hA5);
        end_cycle(1'b1);

        // Sustained collisions saturate the counter.
        reset_pulse();
        set_req(1, 1'b1, 40, 8'h55);
        set_req(2, 1'b1, 40, 8'h66);
        repeat (65540) @(posedge clk);
        @(negedge clk);
        chk("t6_saturated", 32'(conflict_cnt), 32'hFFFF);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_no_wrap", 32'(conflict_cnt), 32'hFFFF);
        bus.req_valid = '0;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
